ssram_regfile: RTL and testbench
================================

Name: ssram_regfile

Overview:
- Parametrised synchronous register bank; successor to the tristate row/column register array and the bit set/reset register.
- Point-to-point bus with req/ack handshake; no tristate data path.
- Atomic per-access write modes: write, set, clear, toggle. Per-bit hardware set inputs for status/flag capture.
- Write strobes for downstream logic. Sits between the CPU bus bridge and peripheral control/status registers.

Parameters:
- WIDTH, 16, register width in bits (>=8).
- DEPTH, 16, number of registers (1..2**AW).
- AW, 4, register index width.
- RESET_VALUE, 0, WIDTH-bit reset value of every register.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- req  input  1  bus transaction request, one transaction per cycle high.
- we  input  1  1 = write, 0 = read; sampled with req.
- addr  input  AW+2  [AW-1:0] register index; [AW+1:AW] write op: 00 write, 01 set, 10 clear, 11 toggle.
- wdata  input  WIDTH  write data or bit mask.
- ack  output  1  one-cycle completion pulse.
- rdata  output  WIDTH  read data; valid with ack.
- hw_set  input  DEPTH*WIDTH  per-bit hardware set, register i at [i*WIDTH +: WIDTH].
- q  output  DEPTH*WIDTH  register contents, same packing.
- wr_pulse  output  DEPTH  one-cycle pulse when register i is written by the bus.

Behaviour:
- Reset (rst=0, async): every register = RESET_VALUE; ack=0; rdata=0; wr_pulse=0. Any in-flight transaction is dropped and gets no ack.
- Handshake: each cycle with req=1 is one transaction. ack=1 exactly one cycle later. Back-to-back req gives continuous ack. req=0 gives ack=0.
- Write (req&we), register idx, next edge:
  - op 00: r <= wdata
  - op 01: r <= r | wdata
  - op 10: r <= r & ~wdata
  - op 11: r <= r ^ wdata
- wr_pulse[idx]=1 in the ack cycle for any write op, including a mask of 0.
- Read (req&~we): rdata <= r[idx] at the edge, i.e. the pre-update value. addr op bits are ignored.
- rdata holds its last value while ack=0. Write transactions do not change rdata.
- Hardware set: every cycle r <= bus_result | hw_set.
  - hw_set wins over a same-cycle clear or write of the same bit.
  - hw_set is level-sensitive; a bit held high cannot be cleared.
- Out-of-range index (idx >= DEPTH): write has no effect and no wr_pulse; read returns 0; ack still issued.
- Read of the register written on the previous cycle returns the new value. Zero read latency hazard beyond that.
- q is registered, never combinational from the bus.

Optional Feature:
- Macro REGFILE_LOCK_EN. When defined, a lock register sits at index DEPTH and requires DEPTH < 2**AW.
- Lock FSM states:
  - LOCKED: reset state. Op-00 write of wdata[7:0]=8'hA5 goes to KEY1.
  - KEY1: next bus transaction, read or write, is checked. Op-00 write of 8'h5A goes to UNLOCKED; anything else goes to LOCKED.
  - UNLOCKED: any write to the lock register goes to LOCKED.
- While LOCKED or KEY1:
  - Bus writes to indices 0..DEPTH-1 are discarded, no wr_pulse, but still acked.
  - hw_set is unaffected.
- Reading the lock register returns {WIDTH-2 zeros, state==KEY1, state==UNLOCKED}.
- Without the macro: no lock register, index DEPTH is out-of-range, all registers always writable.

Test Plan:
- Reset, then read idx 3 -> ack one cycle after req, rdata=RESET_VALUE. Release rst mid-burst -> no ack for dropped req.
- Write 16'h00F0 to idx 2 (op 00), then set 16'h0003 (op 01), clear 16'h0010 (op 10), toggle 16'hFFFF (op 11) -> read 16'hFF1C; four wr_pulse[2] pulses.
- Back-to-back write 16'h1234 idx 5, read idx 5 next cycle -> ack on two consecutive cycles, rdata=16'h1234, q[5]=16'h1234.
- Hold hw_set bit 0 of idx 1 while clearing 16'h0001 -> bit stays 1. Drop hw_set, clear again -> 0.
- Write idx >= DEPTH -> ack, no wr_pulse, q unchanged; read it -> rdata=0.
- With REGFILE_LOCK_EN: write idx 0 -> discarded. Write A5 then 5A to lock reg -> read returns 2'b01, idx 0 writable. A5, then read, then 5A -> stays LOCKED.

Source files
------------

// File: rtl/ssram_regfile.sv
// ssram_regfile: parametrised synchronous register bank on a req/ack point-to-point bus.
//
// Each register supports per-access write, set, clear and toggle operations.
// Per-bit hardware set inputs capture status flags.
// A per-register write strobe tells downstream logic that the bus wrote that register.
//
// Optional feature: define REGFILE_LOCK_EN to add a write-lock register at index DEPTH.
// This requires DEPTH < 2**AW. Writes to the data registers are accepted only while
// the lock is open. The lock opens after the key sequence 8'hA5, 8'h5A is written to
// the lock register (op 00) on consecutive transactions.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   req       one bus transaction per cycle high
//   we        1 = write, 0 = read (sampled with req)
//   addr      [AW-1:0] register index, [AW+1:AW] write op (00 wr, 01 set, 10 clr, 11 tgl)
//   wdata     write data or bit mask
//   ack       completion pulse, one cycle after req
//   rdata     read data, valid with ack, held otherwise
//   hw_set    per-bit hardware set, register i at [i*WIDTH +: WIDTH]
//   q         register contents, same packing as hw_set
//   wr_pulse  per-register pulse in the ack cycle of a bus write
module ssram_regfile #(
  parameter int unsigned      WIDTH       = 16,
  parameter int unsigned      DEPTH       = 16,
  parameter int unsigned      AW          = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic                   we,
  input  logic [AW+1:0]          addr,
  input  logic [WIDTH-1:0]       wdata,
  output logic                   ack,
  output logic [WIDTH-1:0]       rdata,
  input  logic [DEPTH*WIDTH-1:0] hw_set,
  output logic [DEPTH*WIDTH-1:0] q,
  output logic [DEPTH-1:0]       wr_pulse
);

  localparam int unsigned OPW = 2;

  localparam logic [OPW-1:0] OP_WRITE = 2'b00;
  localparam logic [OPW-1:0] OP_SET   = 2'b01;
  localparam logic [OPW-1:0] OP_CLR   = 2'b10;
  localparam logic [OPW-1:0] OP_TGL   = 2'b11;

  logic [AW-1:0]          idx;
  logic [OPW-1:0]         op;
  logic                   wr_en_c;
  logic [WIDTH-1:0]       rd_word_c;
  logic [WIDTH-1:0]       cur_word_c;
  logic [WIDTH-1:0]       bus_word_c;
  logic [DEPTH*WIDTH-1:0] q_next_c;
  logic [DEPTH-1:0]       wr_hit_c;

  assign idx = addr[AW-1:0];
  assign op  = addr[AW+1:AW];

`ifdef REGFILE_LOCK_EN
  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    KEY1     = 2'd1,
    UNLOCKED = 2'd2
  } lock_state_e;

  lock_state_e      lock_state;
  lock_state_e      lock_next_c;
  logic             lock_hit_c;
  logic             lock_key_wr_c;
  logic [WIDTH-1:0] lock_word_c;

  assign lock_hit_c    = (idx == AW'(DEPTH));
  // Only plain writes (op 00) to the lock register count as key writes.
  assign lock_key_wr_c = req && we && lock_hit_c && (op == OP_WRITE);
  assign lock_word_c   = {{(WIDTH-2){1'b0}}, (lock_state == KEY1), (lock_state == UNLOCKED)};
  assign wr_en_c       = (lock_state == UNLOCKED);

  // Lock state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_state <= LOCKED;
    end else begin
      lock_state <= lock_next_c;
    end
  end

  // Lock next-state: KEY1 judges the very next transaction, whatever its target
  always_comb begin
    lock_next_c = lock_state;
    case (lock_state)
      LOCKED: begin
        if (lock_key_wr_c && (wdata[7:0] == 8'hA5)) begin
          lock_next_c = KEY1;
        end
      end
      KEY1: begin
        if (req) begin
          lock_next_c = (lock_key_wr_c && (wdata[7:0] == 8'h5A)) ? UNLOCKED : LOCKED;
        end
      end
      UNLOCKED: begin
        if (req && we && lock_hit_c) begin
          lock_next_c = LOCKED;
        end
      end
      default: lock_next_c = LOCKED;
    endcase
  end
`else
  assign wr_en_c = 1'b1;
`endif

  // Per-register bus result merged with hardware set; read mux (out-of-range reads return 0)
  always_comb begin
    wr_hit_c   = '0;
    rd_word_c  = '0;
    q_next_c   = '0;
    cur_word_c = '0;
    bus_word_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cur_word_c = q[i*WIDTH +: WIDTH];
      bus_word_c = cur_word_c;
      if (idx == AW'(i)) begin
        rd_word_c = cur_word_c;
        if (req && we && wr_en_c) begin
          wr_hit_c[i] = 1'b1;
          case (op)
            OP_WRITE: bus_word_c = wdata;
            OP_SET:   bus_word_c = cur_word_c | wdata;
            OP_CLR:   bus_word_c = cur_word_c & ~wdata;
            OP_TGL:   bus_word_c = cur_word_c ^ wdata;
            default:  bus_word_c = cur_word_c;
          endcase
        end
      end
      // hw_set is applied last, so it wins over a same-cycle clear or write.
      q_next_c[i*WIDTH +: WIDTH] = bus_word_c | hw_set[i*WIDTH +: WIDTH];
    end
`ifdef REGFILE_LOCK_EN
    if (lock_hit_c) begin
      rd_word_c = lock_word_c;
    end
`endif
  end

  // Registers, handshake and strobes; rdata only moves on a read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q        <= {DEPTH{RESET_VALUE}};
      ack      <= 1'b0;
      rdata    <= '0;
      wr_pulse <= '0;
    end else begin
      q        <= q_next_c;
      ack      <= req;
      wr_pulse <= wr_hit_c;
      if (req && !we) begin
        rdata <= rd_word_c;
      end
    end
  end

endmodule

// File: tb/tb_ssram_regfile.sv
// Directed self-checking bench for ssram_regfile (WIDTH 16, DEPTH 12, AW 4).
module tb_ssram_regfile;

  localparam int unsigned      WIDTH    = 16;
  localparam int unsigned      DEPTH    = 12;
  localparam int unsigned      AW       = 4;
  localparam logic [WIDTH-1:0] RV       = 16'h00C3;
  localparam logic [AW-1:0]    LOCK_IDX = 4'd12;

  logic                   clk;
  logic                   rst;
  logic                   req;
  logic                   we;
  logic [AW+1:0]          addr;
  logic [WIDTH-1:0]       wdata;
  logic                   ack;
  logic [WIDTH-1:0]       rdata;
  logic [DEPTH*WIDTH-1:0] hw_set;
  logic [DEPTH*WIDTH-1:0] q;
  logic [DEPTH-1:0]       wr_pulse;

  int n_cmp = 0;
  int n_err = 0;

  ssram_regfile #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .RESET_VALUE(RV)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .hw_set(hw_set), .q(q), .wr_pulse(wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] qw(input int i);
    return q[i*16 +: 16];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction (or idle cycle); outputs are examined 1ns after the edge.
  task automatic bus(input logic r, input logic w, input logic [1:0] o,
                     input logic [3:0] i, input logic [15:0] d);
    req   = r;
    we    = w;
    addr  = {o, i};
    wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic unlock();
`ifdef REGFILE_LOCK_EN
    bus(1, 1, 2'b00, LOCK_IDX, 16'h00A5);
    bus(1, 1, 2'b00, LOCK_IDX, 16'h005A);
`endif
  endtask

  initial begin
    rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; hw_set = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ack", 32'(ack), 32'h0);
    chk("reset_rdata", 32'(rdata), 32'h0);
    chk("reset_wr_pulse", 32'(wr_pulse), 32'h0);
    chk("reset_q3", 32'(qw(3)), 32'(RV));
    chk("reset_q11", 32'(qw(11)), 32'(RV));
    rst = 1'b1;
    unlock();

    // read after reset, then idle
    bus(1, 0, 2'b00, 4'd3, 16'h0);
    chk("rd3_ack", 32'(ack), 32'h1);
    chk("rd3_rdata", 32'(rdata), 32'(RV));
    bus(0, 0, 2'b00, 4'd0, 16'h0);
    chk("idle_ack", 32'(ack), 32'h0);
    chk("idle_rdata_hold", 32'(rdata), 32'(RV));

    // reset asserted while a request is pending: no ack
    req = 1'b1; we = 1'b0; addr = {2'b00, 4'd2};
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("drop_ack", 32'(ack), 32'h0);
    req = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("drop_ack_after", 32'(ack), 32'h0);
    unlock();

    // write modes on idx 2
    bus(1, 1, 2'b00, 4'd2, 16'h00F0);
    chk("wr_ack", 32'(ack), 32'h1);
    chk("wr_q2", 32'(qw(2)), 32'h00F0);
    chk("wr_pulse", 32'(wr_pulse), 32'h004);
    bus(1, 1, 2'b01, 4'd2, 16'h0003);
    chk("set_q2", 32'(qw(2)), 32'h00F3);
    chk("set_pulse", 32'(wr_pulse), 32'h004);
    bus(1, 1, 2'b10, 4'd2, 16'h0010);
    chk("clr_q2", 32'(qw(2)), 32'h00E3);
    chk("clr_pulse", 32'(wr_pulse), 32'h004);
    bus(1, 1, 2'b11, 4'd2, 16'hFFFF);
    chk("tgl_q2", 32'(qw(2)), 32'hFF1C);
    chk("tgl_pulse", 32'(wr_pulse), 32'h004);
    bus(1, 0, 2'b11, 4'd2, 16'h0);
    chk("rd2_rdata", 32'(rdata), 32'hFF1C);
    chk("rd2_pulse", 32'(wr_pulse), 32'h000);

    // back-to-back write then read of idx 5
    bus(1, 1, 2'b00, 4'd5, 16'h1234);
    chk("b2b_ack1", 32'(ack), 32'h1);
    chk("b2b_pulse", 32'(wr_pulse), 32'h020);
    chk("b2b_rdata_kept", 32'(rdata), 32'hFF1C);
    bus(1, 0, 2'b00, 4'd5, 16'h0);
    chk("b2b_ack2", 32'(ack), 32'h1);
    chk("b2b_rdata", 32'(rdata), 32'h1234);
    chk("b2b_q5", 32'(qw(5)), 32'h1234);

    // hw_set beats a bus clear; dropping it lets the clear through
    hw_set[1*16+0] = 1'b1;
    bus(1, 1, 2'b10, 4'd1, 16'h0001);
    chk("hw_hold_q1", 32'(qw(1)), 32'h00C3);
    chk("hw_hold_pulse", 32'(wr_pulse), 32'h002);
    hw_set = '0;
    bus(1, 1, 2'b10, 4'd1, 16'h0001);
    chk("hw_drop_q1", 32'(qw(1)), 32'h00C2);

    // hw_set capture is sticky on an idle register
    hw_set[7*16+15] = 1'b1;
    bus(0, 0, 2'b00, 4'd0, 16'h0);
    chk("hw_cap_q7", 32'(qw(7)), 32'h80C3);
    hw_set = '0;
    bus(0, 0, 2'b00, 4'd0, 16'h0);
    chk("hw_sticky_q7", 32'(qw(7)), 32'h80C3);

    // out-of-range index
    bus(1, 1, 2'b00, 4'd14, 16'hFFFF);
    chk("oor_wr_ack", 32'(ack), 32'h1);
    chk("oor_wr_pulse", 32'(wr_pulse), 32'h000);
    chk("oor_q2", 32'(qw(2)), 32'hFF1C);
    chk("oor_q0", 32'(qw(0)), 32'h00C3);
    bus(1, 0, 2'b00, 4'd14, 16'h0);
    chk("oor_rd_ack", 32'(ack), 32'h1);
    chk("oor_rd_rdata", 32'(rdata), 32'h0);

`ifdef REGFILE_LOCK_EN
    // lock register behaviour
    bus(1, 1, 2'b00, LOCK_IDX, 16'h0000);
    bus(1, 0, 2'b00, LOCK_IDX, 16'h0);
    chk("lk_locked_rd", 32'(rdata), 32'h0);
    bus(1, 1, 2'b00, 4'd0, 16'h5555);
    chk("lk_disc_ack", 32'(ack), 32'h1);
    chk("lk_disc_pulse", 32'(wr_pulse), 32'h000);
    chk("lk_disc_q0", 32'(qw(0)), 32'h00C3);
    bus(1, 1, 2'b00, LOCK_IDX, 16'h00A5);
    bus(1, 0, 2'b00, LOCK_IDX, 16'h0);
    chk("lk_key1_rd", 32'(rdata), 32'h2);
    bus(1, 1, 2'b00, LOCK_IDX, 16'h005A);
    bus(1, 0, 2'b00, LOCK_IDX, 16'h0);
    chk("lk_still_locked", 32'(rdata), 32'h0);
    bus(1, 1, 2'b00, 4'd0, 16'h5555);
    chk("lk_still_q0", 32'(qw(0)), 32'h00C3);
    unlock();
    bus(1, 0, 2'b00, LOCK_IDX, 16'h0);
    chk("lk_unlocked_rd", 32'(rdata), 32'h1);
    bus(1, 1, 2'b00, 4'd0, 16'h5555);
    chk("lk_open_q0", 32'(qw(0)), 32'h5555);
    chk("lk_open_pulse", 32'(wr_pulse), 32'h001);
`else
    // index DEPTH is simply out of range
    bus(1, 1, 2'b00, LOCK_IDX, 16'hFFFF);
    chk("idx12_wr_pulse", 32'(wr_pulse), 32'h000);
    bus(1, 0, 2'b00, LOCK_IDX, 16'h0);
    chk("idx12_rd_ack", 32'(ack), 32'h1);
    chk("idx12_rdata", 32'(rdata), 32'h0);
    chk("idx12_q11", 32'(qw(11)), 32'h00C3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
